// File: rtl/pc.sv
`default_nettype none
// ============================================================================
// Module   : pc
// Purpose  : Loadable WIDTH-bit up-counter with one-cycle rollover pulse.
//            Priority at each rising edge: reset -> load -> increment -> hold.
//            The counter is a bank of per-bit flops, each with its own
//            next-state select.
// Config   : PC_WRAP_FLAG_EN - when defined, 'wrap' pulses for one cycle
//            after an increment rolls the counter from all-ones to zero.
//            When undefined, 'wrap' is tied to 0 and no wrap flop exists.
// Revision : 1.0 - initial release
// ============================================================================
module pc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] incr_val;

    // Incremented value, naturally modulo 2^WIDTH.
    assign incr_val = count_q + WIDTH'(1);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic bit_d;
        logic bit_q;

        // Per-bit next-state select: load wins over increment, else hold.
        always_comb begin
            bit_d = bit_q;
            if (load) begin
                bit_d = in[b];
            end else if (inc) begin
                bit_d = incr_val[b];
            end
        end

        // Per-bit state flop with synchronous active-low clear.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                bit_q <= 1'b0;
            end else begin
                bit_q <= bit_d;
            end
        end

        assign count_q[b] = bit_q;
    end

    assign out = count_q;

`ifdef PC_WRAP_FLAG_EN
    logic wrap_d;
    logic wrap_q;

    // Rollover occurs only on a real increment from all-ones; loads never wrap.
    always_comb begin
        wrap_d = 1'b0;
        if (!load && inc && (&count_q)) begin
            wrap_d = 1'b1;
        end
    end

    // Wrap flag flop, cleared by reset; re-evaluated every edge so it pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`else
    assign wrap = 1'b0;
`endif

endmodule
`default_nettype wire
